program_loader: RTL

Serial program loader that writes the instruction memory the processor fetches from. It receives 8N1 UART bytes on `rx`, assembles them big-endian into 32-bit instruction words, and emits one write per word at consecutive word addresses. While loading, it holds the processor in reset via `cpu_hold`. It sits between the board serial pin and the instruction memory write port, alongside the program counter.

---
 rtl/loader_pkg.sv | 29 ++
 rtl/program_loader_if.sv | 15 +
 rtl/uart_rx.sv | 126 ++++++++++++
 rtl/program_loader.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
//   rx_state_e   : UART receiver FSM states
//   load_state_e : load-session FSM states
//   LOADER_TERMINATOR : word value that ends a session without being written
//   shift_in_byte     : big-endian byte assembly helper
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        L_IDLE = 2'd0,
        L_LOAD = 2'd1,
        L_DONE = 2'd2
    } load_state_e;

    localparam logic [31:0] LOADER_TERMINATOR = 32'hFFFF_FFFF;

    // Earlier bytes move toward the MSB, so the first byte ends in [31:24].
    function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                  input logic [7:0]  new_byte);
        return {word[23:0], new_byte};
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Instruction-memory write port.
//   mem_address : word address of the current write
//   mem_data    : instruction word being written
//   mem_write   : one-cycle write strobe
// master = loader side (drives), slave = memory side (receives).
interface program_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_data;
    logic                  mem_write;

    modport master (output mem_address, output mem_data, output mem_write);
    modport slave  (input  mem_address, input  mem_data, input  mem_write);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer.
//   clock, reset (async, active-low), rx (asynchronous serial input)
//   byte_data  : last good byte, LSB received first
//   byte_valid : one-cycle pulse when a byte with a high stop bit completes
//   stop_error : one-cycle pulse when the stop bit was sampled low
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       stop_error
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL_T = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_T = TW'(CLKS_PER_BIT / 2 - 1);

    logic            rx_meta_q, rx_sync_q;
    rx_state_e       state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_data_q, byte_data_d;
    logic            byte_valid_q, byte_valid_d;
    logic            stop_error_q, stop_error_d;

    // Synchronizer and receiver state registers; rx flops idle high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            state_q      <= IDLE;
            timer_q      <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            byte_data_q  <= 8'h00;
            byte_valid_q <= 1'b0;
            stop_error_q <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            stop_error_q <= stop_error_d;
        end
    end

    // Receiver next-state: half-bit qualify of the start bit, then mid-bit sampling.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q + TW'(1);
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        stop_error_d = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!rx_sync_q) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (timer_q == HALF_T) begin
                    timer_d   = '0;
                    bit_idx_d = 3'd0;
                    // A start bit that is gone by mid-bit is treated as a glitch.
                    if (!rx_sync_q) begin
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (timer_q == FULL_T) begin
                    timer_d = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (timer_q == FULL_T) begin
                    timer_d = '0;
                    state_d = IDLE;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = shift_q;
                    end else begin
                        stop_error_d = 1'b1;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign stop_error = stop_error_q;

endmodule

// File: rtl/program_loader.sv
// Serial program loader: assembles UART bytes big-endian into 32-bit words and
// writes them to consecutive instruction-memory addresses, holding the CPU in
// reset while a session is active.
//   clock, reset (async, active-low), rx (serial in), load_enable (session level)
//   mem_if      : instruction-memory write port (master)
//   cpu_hold    : high while a session is active
//   word_count  : words written this session
//   frame_error : sticky, a stop bit was sampled low
//   overflow    : sticky, a word arrived after memory was full
//   done        : terminator word received
module program_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  load_enable,
    program_loader_if.master      mem_if,
    output logic                  cpu_hold,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  frame_error,
    output logic                  overflow,
    output logic                  done
);
    localparam logic [ADDR_WIDTH:0] MEM_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [7:0]            byte_data_s;
    logic                  byte_valid_s;
    logic                  stop_error_s;
    logic                  load_rise_s;
    logic [31:0]           word_next_s;

    load_state_e           state_q, state_d;
    logic                  load_en_prev_q;
    logic [31:0]           word_q, word_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [31:0]           mem_data_q, mem_data_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic                  frame_error_q, frame_error_d;
    logic                  overflow_q, overflow_d;
    logic                  done_q, done_d;
    logic                  cpu_hold_q, cpu_hold_d;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .byte_data  (byte_data_s),
        .byte_valid (byte_valid_s),
        .stop_error (stop_error_s)
    );

    assign load_rise_s = load_enable & ~load_en_prev_q;
    assign word_next_s = shift_in_byte(word_q, byte_data_s);

    // Session, assembler and address/count registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= L_IDLE;
            load_en_prev_q <= 1'b0;
            word_q         <= 32'h0000_0000;
            byte_cnt_q     <= 2'd0;
            mem_address_q  <= '0;
            mem_data_q     <= 32'h0000_0000;
            mem_write_q    <= 1'b0;
            word_count_q   <= '0;
            frame_error_q  <= 1'b0;
            overflow_q     <= 1'b0;
            done_q         <= 1'b0;
            cpu_hold_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            load_en_prev_q <= load_enable;
            word_q         <= word_d;
            byte_cnt_q     <= byte_cnt_d;
            mem_address_q  <= mem_address_d;
            mem_data_q     <= mem_data_d;
            mem_write_q    <= mem_write_d;
            word_count_q   <= word_count_d;
            frame_error_q  <= frame_error_d;
            overflow_q     <= overflow_d;
            done_q         <= done_d;
            cpu_hold_q     <= cpu_hold_d;
        end
    end

    // Session next-state, byte assembly and write generation.
    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        byte_cnt_d    = byte_cnt_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_write_d   = 1'b0;
        word_count_d  = word_count_q;
        frame_error_d = frame_error_q;
        overflow_d    = overflow_q;
        done_d        = done_q;

        // Address and count advance on the edge that ends the write cycle, so
        // the address is stable while the strobe is high. The address wraps
        // naturally; the count check blocks writes after the wrap.
        if (mem_write_q) begin
            mem_address_d = mem_address_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            word_count_d  = word_count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end else begin
            mem_address_d = mem_address_q;
            word_count_d  = word_count_q;
        end

        if (stop_error_s) begin
            frame_error_d = 1'b1;
        end else begin
            frame_error_d = frame_error_q;
        end

        // Dropping load_enable beats everything, including a 4th byte arriving
        // in the same cycle; any partial word is discarded.
        if (!load_enable) begin
            state_d    = L_IDLE;
            byte_cnt_d = 2'd0;
        end else begin
            case (state_q)
                L_IDLE: begin
                    if (load_rise_s) begin
                        state_d       = L_LOAD;
                        mem_address_d = '0;
                        word_count_d  = '0;
                        byte_cnt_d    = 2'd0;
                        frame_error_d = 1'b0;
                        overflow_d    = 1'b0;
                        done_d        = 1'b0;
                    end else begin
                        state_d = L_IDLE;
                    end
                end
                L_LOAD: begin
                    if (byte_valid_s) begin
                        word_d = word_next_s;
                        if (byte_cnt_q == 2'd3) begin
                            byte_cnt_d = 2'd0;
                            if (word_next_s == LOADER_TERMINATOR) begin
                                state_d = L_DONE;
                                done_d  = 1'b1;
                            end else if (word_count_q == MEM_WORDS) begin
                                overflow_d = 1'b1;
                            end else begin
                                mem_write_d = 1'b1;
                                mem_data_d  = word_next_s;
                            end
                        end else begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                    end else begin
                        state_d = L_LOAD;
                    end
                end
                L_DONE: begin
                    state_d = L_DONE;
                end
                default: begin
                    state_d = L_IDLE;
                end
            endcase
        end

        cpu_hold_d = (state_d != L_IDLE);
    end

    assign mem_if.mem_address = mem_address_q;
    assign mem_if.mem_data    = mem_data_q;
    assign mem_if.mem_write   = mem_write_q;
    assign cpu_hold           = cpu_hold_q;
    assign word_count         = word_count_q;
    assign frame_error        = frame_error_q;
    assign overflow           = overflow_q;
    assign done               = done_q;

endmodule
